// File: rtl/contra_pkg.sv
// contra_pkg: shared player state encoding, sprite image indices and screen geometry
package contra_pkg;
  typedef enum logic [2:0] {IDLE, RUN, JUMP, CROUCH, DYING, GAME_OVER} player_state_t;
  localparam logic [3:0] IMG_STAND = 4'd0, IMG_RUN_A = 4'd1, IMG_RUN_B = 4'd2,
                         IMG_JUMP = 4'd3, IMG_CROUCH = 4'd4, IMG_DEAD = 4'd5;
  localparam int SCREEN_W = 640, SPRITE_W = 30, SPRITE_H = 50;
endpackage

// File: rtl/player_controller_if.sv
// player_controller_if: player key/hit inputs and sprite renderer outputs
interface player_controller_if;
  logic key_left, key_right, key_jump, key_down, hit;
  logic [9:0] pos_x, pos_y;
  logic [3:0] current_image;
  logic face_dir, show_player, game_over;
  logic [1:0] lives;
  modport master(input key_left, key_right, key_jump, key_down, hit,
                 output pos_x, pos_y, current_image, face_dir, show_player, lives, game_over);
  modport slave(output key_left, key_right, key_jump, key_down, hit,
                input pos_x, pos_y, current_image, face_dir, show_player, lives, game_over);
endinterface

// File: rtl/player_controller_frame_tick_sync.sv
// frame_tick_sync: synchronises vsync into the Clk domain and emits a one-cycle pulse per rising edge
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);
  logic s1, s2, s3;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {frame_clk, s1, s2};
  assign tick = s2 & ~s3;
endmodule

// File: rtl/player_controller.sv
// player_controller: per-player motion, animation, death and respawn engine feeding the sprite renderer
module player_controller
  import contra_pkg::*;
#(
  parameter int SPAWN_X       = 40,
  parameter int GROUND_Y      = 380,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = SCREEN_W - SPRITE_W,
  parameter int RUN_SPEED     = 2,
  parameter int JUMP_V        = 10,
  parameter int MAX_FALL      = 12,
  parameter int ANIM_DIV      = 4,
  parameter int DEATH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int LIVES_INIT    = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  player_controller_if.master p
);
  localparam logic signed [10:0] XMIN = 11'(X_MIN), XMAX = 11'(X_MAX), GY = 11'(GROUND_Y), RS = 11'(RUN_SPEED);
  localparam logic signed [5:0] VJ = 6'(JUMP_V), VMAX = 6'(MAX_FALL);
  localparam logic [7:0] DEND = 8'(DEATH_FRAMES - 1), AEND = 8'(ANIM_DIV - 1), INV = 8'(INVULN_FRAMES);
  player_state_t state;
  logic tick, hit_pending, hit_ok, dir;
  logic [9:0] pos_x, pos_y, x_mv;
  logic [3:0] image;
  logic face_dir, show_player, game_over;
  logic [1:0] lives;
  logic signed [5:0] vy, vy_inc;
  logic signed [10:0] x_raw, y_sum;
  logic [7:0] anim_cnt, death_cnt, invuln_cnt, inv_nx;
  frame_tick_sync u_sync (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .tick(tick));
  assign dir = p.key_left ^ p.key_right;
  assign hit_ok = p.hit && state != DYING && state != GAME_OVER && invuln_cnt == 8'd0;
  // Horizontal move is computed wide and signed so saturation never wraps.
  always_comb begin
    x_raw = $signed({1'b0, pos_x}) + (p.key_right ? RS : -RS);
    x_mv = !dir ? pos_x : x_raw < XMIN ? 10'(X_MIN) : x_raw > XMAX ? 10'(X_MAX) : x_raw[9:0];
    y_sum = $signed({1'b0, pos_y}) + $signed({{5{vy[5]}}, vy});
    vy_inc = vy >= VMAX ? VMAX : vy + 6'sd1;
    inv_nx = invuln_cnt == 8'd0 ? 8'd0 : invuln_cnt - 8'd1;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      pos_x <= 10'(SPAWN_X);
      pos_y <= 10'(GROUND_Y);
      image <= IMG_STAND;
      face_dir <= 1'b1;
      show_player <= 1'b1;
      lives <= 2'(LIVES_INIT);
      game_over <= 1'b0;
      hit_pending <= 1'b0;
      vy <= 6'sd0;
      anim_cnt <= 8'd0;
      death_cnt <= 8'd0;
      invuln_cnt <= 8'd0;
    end else if (!tick) begin
      hit_pending <= hit_pending | hit_ok;
    end else begin
      hit_pending <= 1'b0;
      invuln_cnt <= inv_nx;
      show_player <= inv_nx == 8'd0 || !inv_nx[3];
      if (dir && state != DYING && state != GAME_OVER) face_dir <= p.key_right;
      if (state == GAME_OVER) begin
        show_player <= 1'b0;
      end else if (state == DYING) begin
        if (death_cnt != DEND) death_cnt <= death_cnt + 8'd1;
        else if (lives == 2'd0) begin
          state <= GAME_OVER;
          show_player <= 1'b0;
          game_over <= 1'b1;
        end else begin
          state <= IDLE;
          pos_x <= 10'(SPAWN_X);
          pos_y <= 10'(GROUND_Y);
          image <= IMG_STAND;
          face_dir <= 1'b1;
          invuln_cnt <= INV;
          show_player <= !INV[3];
          death_cnt <= 8'd0;
        end
      end else if (hit_pending) begin
        state <= DYING;
        lives <= lives - 2'd1;
        image <= IMG_DEAD;
        death_cnt <= 8'd0;
      end else if (state != JUMP && p.key_jump) begin
        state <= JUMP;
        pos_x <= x_mv;
        pos_y <= pos_y - 10'(JUMP_V);
        vy <= 6'sd1 - VJ;
        image <= IMG_JUMP;
      end else if (state == JUMP) begin
        pos_x <= x_mv;
        vy <= vy_inc;
        if (vy > 6'sd0 && y_sum >= GY) begin
          pos_y <= 10'(GROUND_Y);
          state <= dir ? RUN : IDLE;
          image <= dir ? IMG_RUN_A : IMG_STAND;
          anim_cnt <= 8'd0;
        end else pos_y <= y_sum[9:0];
      end else if (p.key_down) begin
        state <= CROUCH;
        image <= IMG_CROUCH;
      end else if (dir) begin
        state <= RUN;
        pos_x <= x_mv;
        anim_cnt <= state != RUN || anim_cnt == AEND ? 8'd0 : anim_cnt + 8'd1;
        if (state != RUN) image <= IMG_RUN_A;
        else if (anim_cnt == AEND) image <= image == IMG_RUN_A ? IMG_RUN_B : IMG_RUN_A;
      end else begin
        state <= IDLE;
        image <= IMG_STAND;
      end
    end
  assign p.pos_x = pos_x;
  assign p.pos_y = pos_y;
  assign p.current_image = image;
  assign p.face_dir = face_dir;
  assign p.show_player = show_player;
  assign p.lives = lives;
  assign p.game_over = game_over;
endmodule

// File: tb/tb_player_controller.sv
// tb_player_controller: directed frame-by-frame stimulus with a queued scoreboard checked by a monitor
module tb_player_controller;
  logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0;
  player_controller_if bus();
  player_controller dut (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .p(bus));
  always #5 Clk = ~Clk;
  typedef struct {string tag; int f; int v;} exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0, act;
  event chk;
  int jy[21] = '{370, 361, 353, 346, 340, 335, 331, 328, 326, 325, 325,
                 326, 328, 331, 335, 340, 346, 353, 361, 370, 380};
  function automatic int get(int f);
    case (f)
      0: return int'(bus.pos_x);
      1: return int'(bus.pos_y);
      2: return int'(bus.current_image);
      3: return int'(bus.face_dir);
      4: return int'(bus.show_player);
      5: return int'(bus.lives);
      6: return int'(bus.game_over);
      default: return -1;
    endcase
  endfunction
  always @(chk)
    while (q.size() > 0) begin
      e = q.pop_front();
      act = get(e.f);
      total++;
      if (act != e.v) begin
        bad++;
        $display("FAIL %s: got %0d want %0d at %0t", e.tag, act, e.v, $time);
      end
    end
  task automatic ex(string tag, int f, int v);
    q.push_back('{tag, f, v});
  endtask
  task automatic go();
    -> chk;
    #1;
  endtask
  task automatic keys(bit l, bit r, bit j, bit d);
    bus.key_left = l;
    bus.key_right = r;
    bus.key_jump = j;
    bus.key_down = d;
  endtask
  task automatic tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic pulse_hit();
    @(negedge Clk) bus.hit = 1'b1;
    @(negedge Clk) bus.hit = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
  endtask
  initial begin
    keys(0, 0, 0, 0);
    bus.hit = 1'b0;
    repeat (2) @(negedge Clk);
    ex("rst_x", 0, 40); ex("rst_y", 1, 380); ex("rst_img", 2, 0); ex("rst_face", 3, 1);
    ex("rst_show", 4, 1); ex("rst_lives", 5, 3); ex("rst_go", 6, 0); go();
    Reset = 1'b0;
    tick();
    ex("idle_x", 0, 40); ex("idle_y", 1, 380); ex("idle_img", 2, 0); ex("idle_face", 3, 1);
    ex("idle_show", 4, 1); ex("idle_lives", 5, 3); go();
    keys(0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      ex("run_x", 0, 40 + 2 * i); ex("run_img", 2, 1); go();
    end
    tick();
    ex("run_toggle_img", 2, 2); ex("run_x5", 0, 50); ex("run_face", 3, 1); go();
    keys(0, 0, 0, 0);
    tick();
    ex("stop_img", 2, 0); ex("stop_x", 0, 50); go();
    keys(1, 0, 0, 0);
    ticks(25);
    ex("left_x", 0, 0); ex("left_face", 3, 0); go();
    tick();
    ex("left_sat", 0, 0); go();
    keys(0, 1, 0, 0);
    ticks(305);
    ex("right_x", 0, 610); go();
    tick();
    ex("right_sat", 0, 610); ex("right_face", 3, 1); go();
    keys(0, 0, 0, 0);
    do_reset();
    keys(0, 0, 1, 0);
    tick();
    keys(0, 0, 0, 0);
    ex("jump_y1", 1, jy[0]); ex("jump_img1", 2, 3); go();
    for (int i = 1; i <= 20; i++) begin
      tick();
      ex("jump_y", 1, jy[i]); ex("jump_img", 2, i == 20 ? 0 : 3); go();
    end
    ex("jump_x", 0, 40); go();
    keys(0, 0, 1, 0);
    tick();
    keys(0, 0, 0, 0);
    tick();
    ex("jump2_y", 1, 361); go();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    ex("areset_y", 1, 380); ex("areset_img", 2, 0); go();
    @(negedge Clk) Reset = 1'b0;
    keys(0, 1, 0, 0);
    ticks(2);
    ex("prehit_x", 0, 44); go();
    pulse_hit();
    tick();
    ex("hit_img", 2, 5); ex("hit_lives", 5, 2); ex("hit_x", 0, 44); ex("hit_y", 1, 380); go();
    ticks(58);
    ex("dying_img", 2, 5); ex("dying_x", 0, 44); go();
    keys(0, 0, 0, 0);
    tick();
    ex("dying59_img", 2, 5); go();
    tick();
    ex("respawn_x", 0, 40); ex("respawn_y", 1, 380); ex("respawn_img", 2, 0);
    ex("respawn_face", 3, 1); ex("respawn_lives", 5, 2); ex("respawn_show", 4, 0); go();
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (k == 1 || k == 8 || k == 17 || k == 120) begin ex("blink_on", 4, 1); go(); end
      if (k == 9 || k == 16) begin ex("blink_off", 4, 0); go(); end
      if (k == 4) pulse_hit();
      if (k == 5) begin ex("invuln_lives", 5, 2); ex("invuln_img", 2, 0); go(); end
    end
    pulse_hit();
    tick();
    ex("hit2_lives", 5, 1); ex("hit2_img", 2, 5); go();
    ticks(60);
    ex("respawn2_img", 2, 0); ex("respawn2_lives", 5, 1); go();
    ticks(120);
    ex("invuln2_done_show", 4, 1); go();
    pulse_hit();
    tick();
    ex("hit3_lives", 5, 0); go();
    ticks(59);
    ex("dying3_go", 6, 0); go();
    tick();
    ex("over_go", 6, 1); ex("over_show", 4, 0); ex("over_lives", 5, 0); go();
    keys(1, 0, 1, 0);
    ticks(3);
    pulse_hit();
    tick();
    keys(0, 0, 0, 0);
    ex("over_x", 0, 40); ex("over_y", 1, 380); ex("over_img", 2, 5); ex("over_go2", 6, 1);
    ex("over_show2", 4, 0); ex("over_face", 3, 1); go();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    ex("rst2_lives", 5, 3); ex("rst2_go", 6, 0); ex("rst2_show", 4, 1); ex("rst2_img", 2, 0); go();
    @(negedge Clk) Reset = 1'b0;
    keys(1, 0, 0, 0);
    tick();
    ex("lone_left_x", 0, 38); ex("lone_left_face", 3, 0); go();
    keys(1, 1, 0, 0);
    ticks(2);
    ex("both_x", 0, 38); ex("both_face", 3, 0); ex("both_img", 2, 0); go();
    keys(0, 1, 0, 1);
    tick();
    ex("crouch_img", 2, 4); ex("crouch_face", 3, 1); ex("crouch_x", 0, 38); go();
    keys(0, 0, 0, 0);
    repeat (2) @(negedge Clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
